axi_lite_master: RTL and testbench

- AXI4-Lite initiator that converts a simple single-command request/response port into AXI-Lite read and write transactions.
- Supports one outstanding transaction at a time.
- Drives the five AXI-Lite channels toward a slave; it is the bus-side counterpart of the team's axi_lite_slave.
- Serves as the register-access engine for control logic and as the stimulus source for slave regression.

---
 rtl/axi_lite_pkg.sv | 19 +
 rtl/axi_lite_master.sv | 178 +++++++++++++++++
 tb/tb_axi_lite_master.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: AXI4-Lite response codes and the master FSM state encoding,
// shared by axi_lite_master and its bench.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_AW_W = 3'd1,
        WR_B    = 3'd2,
        RD_AR   = 3'd3,
        RD_R    = 3'd4,
        RSP     = 3'd5
    } state_t;

endpackage

// File: rtl/axi_lite_master.sv
// axi_lite_master: AXI4-Lite initiator, one outstanding command at a time.
// A single command/response port is turned into AW+W/B or AR/R bus traffic.
// All handshake outputs are registered: each is the decode of the next state,
// so every output is 0 while reset is asserted and valids drop on the edge of
// their own handshake.
// Optional build macro AXI_LITE_MASTER_ALIGN_CHECK_EN: a command whose address
// is not word aligned issues no bus transaction and is answered with SLVERR.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_axi_clk,
    input  logic                  i_axi_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_wr,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [31:0]           i_cmd_wdata,
    input  logic [3:0]            i_cmd_wstrb,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [31:0]           o_rsp_rdata,
    output logic [1:0]            o_rsp_resp,
    output logic                  o_awvalid,
    output logic [ADDR_WIDTH-1:0] o_awaddr,
    input  logic                  i_awready,
    output logic                  o_wvalid,
    input  logic                  i_wready,
    output logic [31:0]           o_wdata,
    output logic [3:0]            o_wstrb,
    input  logic                  i_bvalid,
    output logic                  o_bready,
    input  logic [1:0]            i_bresp,
    output logic                  o_arvalid,
    input  logic                  i_arready,
    output logic [ADDR_WIDTH-1:0] o_araddr,
    input  logic                  i_rvalid,
    output logic                  o_rready,
    input  logic [1:0]            i_rresp,
    input  logic [31:0]           i_rdata
);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  aw_done;
    logic                  w_done;
    logic                  aw_done_d;
    logic                  w_done_d;
    logic                  cmd_ready_d;
    logic                  awvalid_d;
    logic                  wvalid_d;
    logic                  bready_d;
    logic                  arvalid_d;
    logic                  rready_d;
    logic                  rsp_valid_d;
    logic                  cmd_acc;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  b_hs;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  rsp_hs;
    logic                  misaligned;

    assign cmd_acc = i_cmd_valid & o_cmd_ready;
    assign aw_hs   = o_awvalid & i_awready;
    assign w_hs    = o_wvalid & i_wready;
    assign b_hs    = i_bvalid & o_bready;
    assign ar_hs   = o_arvalid & i_arready;
    assign r_hs    = i_rvalid & o_rready;
    assign rsp_hs  = o_rsp_valid & i_rsp_ready;

    // AW and W complete independently; a channel counts as done from the
    // edge of its own handshake onward.
    assign aw_done_d = aw_done | aw_hs;
    assign w_done_d  = w_done | w_hs;

`ifdef AXI_LITE_MASTER_ALIGN_CHECK_EN
    assign misaligned = |i_cmd_addr[1:0];
`else
    assign misaligned = 1'b0;
`endif

    // Both address channels carry the single latched command address.
    assign o_awaddr = addr_q;
    assign o_araddr = addr_q;

    // State register and registered handshake outputs.
    always_ff @(posedge i_axi_clk) begin
        if (!i_axi_rst) begin
            state       <= IDLE;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            o_cmd_ready <= 1'b0;
            o_awvalid   <= 1'b0;
            o_wvalid    <= 1'b0;
            o_bready    <= 1'b0;
            o_arvalid   <= 1'b0;
            o_rready    <= 1'b0;
            o_rsp_valid <= 1'b0;
        end else begin
            state       <= state_next;
            aw_done     <= (state_next == WR_AW_W) & aw_done_d;
            w_done      <= (state_next == WR_AW_W) & w_done_d;
            o_cmd_ready <= cmd_ready_d;
            o_awvalid   <= awvalid_d;
            o_wvalid    <= wvalid_d;
            o_bready    <= bready_d;
            o_arvalid   <= arvalid_d;
            o_rready    <= rready_d;
            o_rsp_valid <= rsp_valid_d;
        end
    end

    // Next-state logic: advance on the handshake that completes each phase.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_acc) begin
                    if (misaligned)    state_next = RSP;
                    else if (i_cmd_wr) state_next = WR_AW_W;
                    else               state_next = RD_AR;
                end
            end
            WR_AW_W: if (aw_done_d && w_done_d) state_next = WR_B;
            WR_B:    if (b_hs)                  state_next = RSP;
            RD_AR:   if (ar_hs)                 state_next = RD_R;
            RD_R:    if (r_hs)                  state_next = RSP;
            RSP:     if (rsp_hs)                state_next = IDLE;
            default:                            state_next = IDLE;
        endcase
    end

    // Output decode of the next state; a write valid stays low once its
    // channel has handshaken, so readies only follow completed requests.
    always_comb begin
        cmd_ready_d = (state_next == IDLE);
        awvalid_d   = (state_next == WR_AW_W) & ~aw_done_d;
        wvalid_d    = (state_next == WR_AW_W) & ~w_done_d;
        bready_d    = (state_next == WR_B);
        arvalid_d   = (state_next == RD_AR);
        rready_d    = (state_next == RD_R);
        rsp_valid_d = (state_next == RSP);
    end

    // Command latch on acceptance and response capture on B/R handshake.
    always_ff @(posedge i_axi_clk) begin
        if (!i_axi_rst) begin
            addr_q      <= '0;
            o_wdata     <= '0;
            o_wstrb     <= '0;
            o_rsp_rdata <= '0;
            o_rsp_resp  <= RESP_OKAY;
        end else begin
            if (cmd_acc) begin
                addr_q  <= i_cmd_addr;
                o_wdata <= i_cmd_wdata;
                o_wstrb <= i_cmd_wstrb;
                if (misaligned) begin
                    o_rsp_rdata <= '0;
                    o_rsp_resp  <= RESP_SLVERR;
                end
            end
            if (b_hs) begin
                o_rsp_rdata <= '0;
                o_rsp_resp  <= i_bresp;
            end
            if (r_hs) begin
                o_rsp_rdata <= i_rdata;
                o_rsp_resp  <= i_rresp;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: bench for axi_lite_master with a behavioural AXI-Lite
// slave (configurable per-channel wait states and response codes) and a
// scoreboard of expected responses. Honours AXI_LITE_MASTER_ALIGN_CHECK_EN.
module tb_axi_lite_master;

    logic        i_axi_clk;
    logic        i_axi_rst;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_wr;
    logic [31:0] i_cmd_addr;
    logic [31:0] i_cmd_wdata;
    logic [3:0]  i_cmd_wstrb;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_rsp_resp;
    logic        o_awvalid;
    logic [31:0] o_awaddr;
    logic        i_awready;
    logic        o_wvalid;
    logic        i_wready;
    logic [31:0] o_wdata;
    logic [3:0]  o_wstrb;
    logic        i_bvalid;
    logic        o_bready;
    logic [1:0]  i_bresp;
    logic        o_arvalid;
    logic        i_arready;
    logic [31:0] o_araddr;
    logic        i_rvalid;
    logic        o_rready;
    logic [1:0]  i_rresp;
    logic [31:0] i_rdata;

    axi_lite_master #(.ADDR_WIDTH(32)) dut (
        .i_axi_clk  (i_axi_clk),
        .i_axi_rst  (i_axi_rst),
        .i_cmd_valid(i_cmd_valid),
        .o_cmd_ready(o_cmd_ready),
        .i_cmd_wr   (i_cmd_wr),
        .i_cmd_addr (i_cmd_addr),
        .i_cmd_wdata(i_cmd_wdata),
        .i_cmd_wstrb(i_cmd_wstrb),
        .o_rsp_valid(o_rsp_valid),
        .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_resp (o_rsp_resp),
        .o_awvalid  (o_awvalid),
        .o_awaddr   (o_awaddr),
        .i_awready  (i_awready),
        .o_wvalid   (o_wvalid),
        .i_wready   (i_wready),
        .o_wdata    (o_wdata),
        .o_wstrb    (o_wstrb),
        .i_bvalid   (i_bvalid),
        .o_bready   (o_bready),
        .i_bresp    (i_bresp),
        .o_arvalid  (o_arvalid),
        .i_arready  (i_arready),
        .o_araddr   (o_araddr),
        .i_rvalid   (i_rvalid),
        .o_rready   (o_rready),
        .i_rresp    (i_rresp),
        .i_rdata    (i_rdata)
    );

    initial begin
        i_axi_clk = 1'b0;
        forever #5 i_axi_clk = ~i_axi_clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Slave knobs (written only between transactions) and storage.
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    logic [31:0] mem   [16];
    logic [31:0] model [16];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Behavioural slave: decides readies/valids on the falling edge so the
    // handshakes happen on the following rising edge.
    initial begin
        int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
        logic got_aw = 0, got_w = 0, b_pend = 0, b_fire = 0, r_pend = 0, r_fire = 0;
        logic [31:0] aw_q = 0, w_q = 0, r_q = 0;
        logic [3:0]  s_q = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = 0;
        i_arready = 0; i_rvalid = 0; i_rresp = 0; i_rdata = 0;
        forever begin
            @(negedge i_axi_clk);
            if (!i_axi_rst) begin
                i_awready = 0; i_wready = 0; i_bvalid = 0; i_arready = 0; i_rvalid = 0;
                got_aw = 0; got_w = 0; b_pend = 0; b_fire = 0; r_pend = 0; r_fire = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
                continue;
            end
            if (b_fire) begin i_bvalid = 0; b_fire = 0; end
            if (b_pend) begin
                if (b_wait >= b_delay) begin i_bvalid = 1; i_bresp = b_resp_cfg; end
                b_wait++;
                if (i_bvalid && o_bready) begin b_fire = 1; b_pend = 0; end
            end
            if (r_fire) begin i_rvalid = 0; r_fire = 0; end
            if (r_pend) begin
                if (r_wait >= r_delay) begin i_rvalid = 1; i_rresp = r_resp_cfg; i_rdata = r_q; end
                r_wait++;
                if (i_rvalid && o_rready) begin r_fire = 1; r_pend = 0; end
            end
            if (o_awvalid && !got_aw) begin
                i_awready = (aw_wait >= aw_delay);
                aw_wait++;
                if (i_awready) begin got_aw = 1; aw_q = o_awaddr; end
            end else begin
                i_awready = 0; aw_wait = 0;
            end
            if (o_wvalid && !got_w) begin
                i_wready = (w_wait >= w_delay);
                w_wait++;
                if (i_wready) begin got_w = 1; w_q = o_wdata; s_q = o_wstrb; end
            end else begin
                i_wready = 0; w_wait = 0;
            end
            if (got_aw && got_w) begin
                mem[aw_q[5:2]] = merge(mem[aw_q[5:2]], w_q, s_q);
                got_aw = 0; got_w = 0; b_pend = 1; b_wait = 0;
            end
            if (o_arvalid) begin
                i_arready = (ar_wait >= ar_delay);
                ar_wait++;
                if (i_arready) begin r_pend = 1; r_wait = 0; r_q = mem[o_araddr[5:2]]; end
            end else begin
                i_arready = 0; ar_wait = 0;
            end
        end
    end

    // Scoreboard of expected {rdata, resp}, one entry per accepted command.
    logic [33:0] sb[$];

    // Issues one command from a falling edge, tracks channel activity per
    // cycle after acceptance, holds off the response for 'hold' cycles and
    // compares the response against the scoreboard head.
    task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [31:0] exp_rdata,
                          input logic [1:0] exp_resp, input int hold,
                          output int lat, output int aw_n, output int w_n,
                          output int b_first, output int ar_n);
        int n;
        logic [33:0] exp;
        lat = 0; aw_n = 0; w_n = 0; b_first = 0; ar_n = 0;
        sb.push_back({exp_rdata, exp_resp});
        i_cmd_valid = 1; i_cmd_wr = wr; i_cmd_addr = addr; i_cmd_wdata = data; i_cmd_wstrb = strb;
        n = 0;
        while (!o_cmd_ready && n < 20) begin @(negedge i_axi_clk); n++; end
        if (!o_cmd_ready) begin
            check_eq("accept_timeout", 0, 1);
            i_cmd_valid = 0;
            void'(sb.pop_back());
            return;
        end
        @(negedge i_axi_clk);
        i_cmd_valid = 0;
        n = 1;
        while (!o_rsp_valid && n < 60) begin
            if (o_awvalid) begin aw_n++; check_eq("awaddr", o_awaddr, addr); end
            if (o_wvalid) begin
                w_n++;
                check_eq("wdata", o_wdata, data);
                check_eq("wstrb", o_wstrb, strb);
            end
            if (o_arvalid) begin ar_n++; check_eq("araddr", o_araddr, addr); end
            if (o_bready && b_first == 0) b_first = n;
            @(negedge i_axi_clk);
            n++;
        end
        lat = n;
        if (!o_rsp_valid) begin
            check_eq("rsp_timeout", 0, 1);
            void'(sb.pop_front());
            return;
        end
        exp = sb[0];
        if (hold > 0) begin
            i_cmd_valid = 1; i_cmd_wr = 1; i_cmd_addr = 32'h3C;
            for (int h = 0; h < hold; h++) begin
                @(negedge i_axi_clk);
                check_eq("hold_rsp_valid", o_rsp_valid, 1);
                check_eq("hold_rdata", o_rsp_rdata, exp[33:2]);
                check_eq("hold_resp", o_rsp_resp, exp[1:0]);
                check_eq("hold_cmd_ready", o_cmd_ready, 0);
            end
            i_cmd_valid = 0;
        end
        exp = sb.pop_front();
        check_eq("rsp_rdata", o_rsp_rdata, exp[33:2]);
        check_eq("rsp_resp", o_rsp_resp, exp[1:0]);
        i_rsp_ready = 1;
        @(negedge i_axi_clk);
        i_rsp_ready = 0;
        check_eq("rsp_valid_drop", o_rsp_valid, 0);
        check_eq("cmd_ready_back", o_cmd_ready, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctrl"},
                 {o_cmd_ready, o_rsp_valid, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready}, 0);
        check_eq({tag, "_addr"}, {o_awaddr, o_araddr}, 0);
        check_eq({tag, "_data"}, {o_wdata, o_rsp_rdata}, 0);
        check_eq({tag, "_strb_resp"}, {o_wstrb, o_rsp_resp}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, aw_n, w_n, b_first, ar_n;
        logic [31:0] a, d;
        logic [3:0]  s;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        i_axi_rst = 0; i_cmd_valid = 0; i_cmd_wr = 0; i_cmd_addr = 0;
        i_cmd_wdata = 0; i_cmd_wstrb = 0; i_rsp_ready = 0;

        // Reset state, then ready on the first edge after release.
        repeat (3) @(negedge i_axi_clk);
        check_all_zero("reset");
        i_axi_rst = 1;
        @(negedge i_axi_clk);
        check_eq("ready_after_reset", o_cmd_ready, 1);

        // Zero-wait write.
        do_cmd(1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00, 0, lat, aw_n, w_n, b_first, ar_n);
        model[4] = merge(model[4], 32'hDEADBEEF, 4'hF);
        check_eq("wr_lat", lat, 3);
        check_eq("wr_aw_cycles", aw_n, 1);
        check_eq("wr_w_cycles", w_n, 1);
        check_eq("wr_bready_cycle", b_first, 2);

        // Read back the written word.
        do_cmd(0, 32'h10, 32'h0, 4'h0, model[4], 2'b00, 0, lat, aw_n, w_n, b_first, ar_n);
        check_eq("rd_lat", lat, 3);
        check_eq("rd_ar_cycles", ar_n, 1);

        // AW delayed 3 cycles, W immediate; partial strobes.
        aw_delay = 3;
        do_cmd(1, 32'h20, 32'h12345678, 4'h3, 32'h0, 2'b00, 0, lat, aw_n, w_n, b_first, ar_n);
        model[8] = merge(model[8], 32'h12345678, 4'h3);
        aw_delay = 0;
        check_eq("skew_aw_cycles", aw_n, 4);
        check_eq("skew_w_cycles", w_n, 1);
        check_eq("skew_bready_cycle", b_first, 5);
        check_eq("skew_lat", lat, 6);

        // W delayed 2 cycles, AW immediate.
        w_delay = 2;
        do_cmd(1, 32'h24, 32'hA5A5_0F0F, 4'hC, 32'h0, 2'b00, 0, lat, aw_n, w_n, b_first, ar_n);
        model[9] = merge(model[9], 32'hA5A5_0F0F, 4'hC);
        w_delay = 0;
        check_eq("wskew_aw_cycles", aw_n, 1);
        check_eq("wskew_w_cycles", w_n, 3);
        check_eq("wskew_bready_cycle", b_first, 4);

        do_cmd(0, 32'h20, 32'h0, 4'h0, model[8], 2'b00, 0, lat, aw_n, w_n, b_first, ar_n);
        do_cmd(0, 32'h24, 32'h0, 4'h0, model[9], 2'b00, 0, lat, aw_n, w_n, b_first, ar_n);

        // Response backpressure for 5 cycles with a competing command.
        do_cmd(0, 32'h10, 32'h0, 4'h0, model[4], 2'b00, 5, lat, aw_n, w_n, b_first, ar_n);
        check_eq("bp_lat", lat, 3);

        // Slave errors pass through.
        b_resp_cfg = 2'b11;
        do_cmd(1, 32'h30, 32'hCAFEF00D, 4'hF, 32'h0, 2'b11, 0, lat, aw_n, w_n, b_first, ar_n);
        model[12] = merge(model[12], 32'hCAFEF00D, 4'hF);
        b_resp_cfg = 2'b00;
        r_resp_cfg = 2'b10; r_delay = 2;
        do_cmd(0, 32'h30, 32'h0, 4'h0, model[12], 2'b10, 0, lat, aw_n, w_n, b_first, ar_n);
        r_resp_cfg = 2'b00; r_delay = 0;
        check_eq("rerr_lat", lat, 5);

        // Misaligned read.
`ifdef AXI_LITE_MASTER_ALIGN_CHECK_EN
        do_cmd(0, 32'h13, 32'h0, 4'h0, 32'h0, 2'b10, 0, lat, aw_n, w_n, b_first, ar_n);
        check_eq("misalign_lat", lat, 1);
        check_eq("misalign_no_ar", ar_n, 0);
`else
        do_cmd(0, 32'h13, 32'h0, 4'h0, model[4], 2'b00, 0, lat, aw_n, w_n, b_first, ar_n);
        check_eq("misalign_lat", lat, 3);
        check_eq("misalign_ar_cycles", ar_n, 1);
`endif

        // Reset while AR is outstanding.
        ar_delay = 1000;
        i_cmd_valid = 1; i_cmd_wr = 0; i_cmd_addr = 32'h40;
        @(negedge i_axi_clk);
        i_cmd_valid = 0;
        check_eq("pre_reset_arvalid", o_arvalid, 1);
        i_axi_rst = 0;
        @(negedge i_axi_clk);
        check_all_zero("midreset");
        i_axi_rst = 1;
        ar_delay = 0;
        @(negedge i_axi_clk);
        check_eq("ready_after_midreset", o_cmd_ready, 1);

        // Random write/read-back pairs with random wait states.
        for (int t = 0; t < 8; t++) begin
            a = 32'($urandom_range(0, 15)) << 2;
            d = $urandom;
            s = 4'($urandom_range(1, 15));
            aw_delay = $urandom_range(0, 2); w_delay = $urandom_range(0, 2);
            b_delay = $urandom_range(0, 2);
            do_cmd(1, a, d, s, 32'h0, 2'b00, 0, lat, aw_n, w_n, b_first, ar_n);
            model[a[5:2]] = merge(model[a[5:2]], d, s);
            check_eq("rnd_bready_after_aw_w", b_first > aw_n && b_first > w_n, 1);
            ar_delay = $urandom_range(0, 2); r_delay = $urandom_range(0, 2);
            do_cmd(0, a, 32'h0, 4'h0, model[a[5:2]], 2'b00, $urandom_range(0, 2),
                   lat, aw_n, w_n, b_first, ar_n);
        end
        check_eq("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
